// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the fetch stage
package core_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_aligned(input logic [DATA_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// rtl/fetch_perf_counter.sv - 32-bit saturating event counter with enable
module fetch_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] cnt
);

  // Stick at all-ones rather than wrapping so long runs never read as short ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch control FSM (BOOT/RUN/HALT), optional perf counters under FETCH_PERF_EN
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  input  logic                  resume_i,
  output logic                  pc_we_o,
  output logic [DATA_WIDTH-1:0] next_pc_o,
  output logic                  if_valid_o,
  output logic                  flush_o,
  output logic                  halted_o,
  output logic                  misalign_o,
  output logic [31:0]           fetch_cnt_o,
  output logic [31:0]           stall_cnt_o
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         set_misalign;
  logic         clr_misalign;
  logic         redirect_ok;
  logic         redirect_bad;

  assign redirect_ok  = redirect_i &&  is_aligned(redirect_pc_i);
  assign redirect_bad = redirect_i && !is_aligned(redirect_pc_i);

  // Outputs are decoded combinationally so the PC reacts in the same cycle.
  always_comb begin
    state_d      = state_q;
    pc_we_o      = 1'b0;
    next_pc_o    = pc_i;
    if_valid_o   = 1'b0;
    flush_o      = 1'b0;
    set_misalign = 1'b0;
    clr_misalign = 1'b0;

    case (state_q)
      BOOT: begin
        pc_we_o   = 1'b1;
        next_pc_o = RESET_PC;
        state_d   = RUN;
      end

      RUN: begin
        if (redirect_ok) begin
          pc_we_o   = 1'b1;
          next_pc_o = redirect_pc_i;
          flush_o   = 1'b1;
        end else if (redirect_bad) begin
          flush_o      = 1'b1;
          set_misalign = 1'b1;
          state_d      = HALT;
        end else if (halt_i) begin
          flush_o = 1'b1;
          state_d = HALT;
        end else if (stall_i) begin
          if_valid_o = 1'b1;
        end else begin
          pc_we_o    = 1'b1;
          next_pc_o  = pc_i + PC_STEP;
          if_valid_o = 1'b1;
        end
      end

      HALT: begin
        // A misaligned target is dropped here; the core is already stopped.
        if (redirect_ok) begin
          pc_we_o   = 1'b1;
          next_pc_o = redirect_pc_i;
          flush_o   = 1'b1;
        end
        if (resume_i) begin
          clr_misalign = 1'b1;
          state_d      = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      misalign_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_misalign) begin
        misalign_o <= 1'b1;
      end else if (clr_misalign) begin
        misalign_o <= 1'b0;
      end
    end
  end

  assign halted_o = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic fetch_en;
  logic stall_en;

  assign fetch_en = if_valid_o && !stall_i;
  assign stall_en = (state_q == RUN) && stall_i;

  fetch_perf_counter u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fetch_en),
    .cnt   (fetch_cnt_o)
  );

  fetch_perf_counter u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .cnt   (stall_cnt_o)
  );
`else
  assign fetch_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed plus random checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        resume_i;
  logic        pc_we_o;
  logic [31:0] next_pc_o;
  logic        if_valid_o;
  logic        flush_o;
  logic        halted_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=booting, 1=running, 2=halted
  int          m_mode;
  logic        m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  logic [31:0] m_sc;

  logic        e_we, e_iv, e_fl, e_h, e_chk;
  logic [31:0] e_npc;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .resume_i      (resume_i),
    .pc_we_o       (pc_we_o),
    .next_pc_o     (next_pc_o),
    .if_valid_o    (if_valid_o),
    .flush_o       (flush_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic target_ok();
    return (redirect_pc_i % 4) == 0;
  endfunction

  task automatic predict();
    logic [31:0] seq;
    e_we = 0; e_iv = 0; e_fl = 0; e_h = 0; e_chk = 0; e_npc = 32'h0;
    seq = m_pc + 32'd4;
    if (m_mode == 0) begin
      e_we = 1; e_npc = RST_PC;
    end else if (m_mode == 1) begin
      if (redirect_i && target_ok()) begin
        e_we = 1; e_npc = redirect_pc_i; e_fl = 1;
      end else if (redirect_i || halt_i) begin
        e_fl = 1;
      end else if (stall_i) begin
        e_iv = 1; e_npc = m_pc; e_chk = 1;
      end else begin
        e_we = 1; e_npc = seq; e_iv = 1;
      end
    end else begin
      e_h = 1;
      if (redirect_i && target_ok()) begin
        e_we = 1; e_npc = redirect_pc_i; e_fl = 1;
      end
    end
  endtask

  task automatic check_outputs();
    predict();
    check("pc_we", pc_we_o, e_we);
    if (e_we || e_chk) check("next_pc", next_pc_o, e_npc);
    check("if_valid", if_valid_o, e_iv);
    check("flush", flush_o, e_fl);
    check("halted", halted_o, e_h);
    check("misalign", misalign_o, m_mis);
    check("fetch_cnt", fetch_cnt_o, cnt_exp(m_fc));
    check("stall_cnt", stall_cnt_o, cnt_exp(m_sc));
  endtask

  task automatic advance();
    if (e_iv && !stall_i && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    if (m_mode == 1 && stall_i && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (e_we) m_pc = e_npc;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (redirect_i && !target_ok()) begin
          m_mode = 2; m_mis = 1;
        end else if (!redirect_i && halt_i) begin
          m_mode = 2;
        end
      end
      default: begin
        if (resume_i) begin
          m_mode = 1; m_mis = 0;
        end
      end
    endcase
  endtask

  task automatic set_in(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic ht, input logic rs);
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc; halt_i = ht; resume_i = rs;
  endtask

  task automatic cycle();
    pc_i = m_pc;
    @(negedge clk);
    check_outputs();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_mis = 0; m_fc = 0; m_sc = 0;
  endtask

  // Asynchronous assert a little after an edge, hold one edge, release.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    set_in(0, 0, 0, 0, 0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_i = 0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    m_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Boot then first sequential fetch from RESET_PC
    cycle();
    cycle();
    cycle();

    // Three-cycle stall at 0x200
    m_pc = 32'h200;
    set_in(1, 0, 0, 0, 0);
    repeat (3) cycle();

    // Redirect beats concurrent halt and stall
    set_in(1, 1, 32'h400, 1, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();

    // Misaligned redirect faults into HALT, resume clears it
    set_in(0, 1, 32'h402, 0, 0);
    cycle();
    set_in(0, 0, 0, 1, 0);
    cycle();
    set_in(0, 1, 32'h800, 0, 0);
    cycle();
    set_in(0, 1, 32'h900, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 1);
    cycle();

    // PC wrap
    m_pc = 32'hFFFF_FFFC;
    set_in(0, 0, 0, 0, 0);
    cycle();
    cycle();

    // Reset while halted
    set_in(0, 0, 0, 1, 0);
    cycle();
    set_in(0, 0, 0, 0, 0);
    cycle();
    pulse_reset();
    cycle();
    cycle();

    // Random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rpc,
             $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      if (i == 300) pulse_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port pc_i  input  DATA_WIDTH  current PC from the program counter.
REQ-005 SHALL have port stall_i  input  1  hazard stall; hold the PC and the fetched instruction.
REQ-006 SHALL have port redirect_i  input  1  taken branch/jump resolved downstream.
REQ-007 SHALL have port redirect_pc_i  input  DATA_WIDTH  redirect target.
REQ-008 SHALL have port halt_i  input  1  halt request (ebreak/ecall/debug).
REQ-009 SHALL have port resume_i  input  1  leave HALT.
REQ-010 SHALL have port pc_we_o  output  1  program-counter write enable.
REQ-011 SHALL have port next_pc_o  output  DATA_WIDTH  value written to the PC when pc_we_o=1.
REQ-012 SHALL have port if_valid_o  output  1  current instruction memory output is a valid fetch.
REQ-013 SHALL have port flush_o  output  1  clear IF/ID register this cycle.
REQ-014 SHALL have ports halted_o and misalign_o  output  1 each  state in HALT; sticky misaligned-redirect fault.
REQ-015 SHALL have ports fetch_cnt_o and stall_cnt_o  output  32 each  performance counters (see Configuration).

Function
REQ-016 SHALL implement states BOOT, RUN and HALT; outputs combinational from state and inputs (zero-latency control of the PC).
REQ-017 BOOT SHALL drive pc_we_o=1, next_pc_o=RESET_PC, if_valid_o=0, flush_o=0, and go to RUN next cycle unconditionally.
REQ-018 RUN priority SHALL be: redirect_i > halt_i > stall_i > sequential.
REQ-019 RUN sequential: pc_we_o=1, next_pc_o=pc_i+4 modulo 2^32 (FFFF_FFFC wraps to 0000_0000), if_valid_o=1.
REQ-020 RUN stall: pc_we_o=0, if_valid_o=1, next_pc_o=pc_i; state stays RUN.
REQ-021 RUN aligned redirect (redirect_pc_i[1:0]=0): pc_we_o=1, next_pc_o=redirect_pc_i, flush_o=1, if_valid_o=0; state stays RUN; overrides a concurrent stall_i or halt_i.
REQ-022 RUN misaligned redirect: pc_we_o=0, flush_o=1, if_valid_o=0, misalign_o set next cycle, state goes to HALT.
REQ-023 RUN halt_i (no redirect): pc_we_o=0, if_valid_o=0, flush_o=1, state goes to HALT.
REQ-024 HALT: pc_we_o=0, if_valid_o=0, halted_o=1; aligned redirect_i writes the PC (pc_we_o=1, flush_o=1) without leaving HALT.
REQ-025 HALT resume_i: go to RUN next cycle and clear misalign_o; resume_i with aligned redirect_i in the same cycle applies the redirect and goes to RUN.
REQ-026 resume_i outside HALT, and halt_i inside HALT, SHALL be ignored.

Reset
REQ-027 rst_n low SHALL force state=BOOT, misalign_o=0 and counters=0 immediately; outputs then read pc_we_o=1, next_pc_o=RESET_PC, if_valid_o=0, flush_o=0, halted_o=0.
REQ-028 Reset asserted mid-redirect or in HALT SHALL discard all pending state; the first post-reset cycle is BOOT.

Configuration
REQ-029 With FETCH_PERF_EN defined, fetch_cnt_o SHALL count cycles with if_valid_o=1 and stall_i=0, and stall_cnt_o SHALL count RUN cycles with stall_i=1; both saturate at FFFF_FFFF.
REQ-030 Without FETCH_PERF_EN, fetch_cnt_o and stall_cnt_o SHALL remain ports, tied to 0, with no counter flops.

Structure
REQ-031 core_pkg SHALL hold typedef enum fetch_state_e (BOOT, RUN, HALT; 2 bits) and PC_STEP=4; DATA_WIDTH comes from core_pkg.
REQ-032 One sub-module fetch_perf_counter (32-bit saturating, enable input) SHALL be instantiated twice, only under FETCH_PERF_EN.

Verification
REQ-033 Reset release, RESET_PC=0x100 -> cycle 0 pc_we_o=1 next_pc_o=0x100 if_valid_o=0; cycle 1 next_pc_o=0x104 if_valid_o=1.
REQ-034 pc_i=0x200, stall_i=1 for 3 cycles -> pc_we_o=0 for 3 cycles, if_valid_o=1; stall_cnt_o +3 with FETCH_PERF_EN.
REQ-035 stall_i=1, halt_i=1, redirect_i=1 to 0x400 same cycle -> pc_we_o=1, next_pc_o=0x400, flush_o=1, state stays RUN.
REQ-036 redirect_pc_i=0x402 -> pc_we_o=0, next cycle halted_o=1, misalign_o=1; resume_i -> RUN, misalign_o=0.
REQ-037 pc_i=0xFFFF_FFFC sequential -> next_pc_o=0x0000_0000; rst_n low while in HALT -> halted_o=0 at once, BOOT after release.
